// File: rtl/iob_vga_sync_pkg.sv
// Default 640x480@60 timing, RGB field slices and total helper
// for the VGA raster generator.
package iob_vga_sync_pkg;

  localparam int DefClkDiv = 4;
  localparam int DefHActive = 640;
  localparam int DefHFp = 16;
  localparam int DefHSync = 96;
  localparam int DefHBp = 48;
  localparam int DefVActive = 480;
  localparam int DefVFp = 10;
  localparam int DefVSync = 2;
  localparam int DefVBp = 33;
  localparam int DefCntW = 10;

  localparam int RHi = 11;
  localparam int RLo = 8;
  localparam int GHi = 7;
  localparam int GLo = 4;
  localparam int BHi = 3;
  localparam int BLo = 0;

  function automatic int vga_total(
    input int act,
    input int fp,
    input int sync,
    input int bp
  );
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/iob_vga_counter.sv
// Mod-N counter with enable, synchronous reset and a wrap flag
// that is high on the enabled cycle leaving N-1.
module iob_vga_counter #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);

  localparam logic [W-1:0] Last = W'(N - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign wrap_o = en_i && (cnt_q == Last);
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/iob_vga_sync.sv
// VGA raster timing generator with registered, blanked sync/RGB.
// Define VGA_FRAME_CNT_EN to add the 32-bit frame_cnt port.
module iob_vga_sync
  import iob_vga_sync_pkg::*;
#(
  parameter int CLK_DIV  = DefClkDiv,
  parameter int H_ACTIVE = DefHActive,
  parameter int H_FP     = DefHFp,
  parameter int H_SYNC   = DefHSync,
  parameter int H_BP     = DefHBp,
  parameter int V_ACTIVE = DefVActive,
  parameter int V_FP     = DefVFp,
  parameter int V_SYNC   = DefVSync,
  parameter int V_BP     = DefVBp,
  parameter int CNT_W    = DefCntW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [11:0]      vga_rgb_in,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             video_on,
  output logic             frame_start,
  output logic             vga_hs,
  output logic             vga_vs,
  output logic [3:0]       vga_r,
  output logic [3:0]       vga_g,
  output logic [3:0]       vga_b
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [31:0]      frame_cnt
`endif
);

  localparam int HTotal = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int VTotal = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [CNT_W-1:0] HsBeg = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HsEnd = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VsBeg = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VsEnd = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [CNT_W-1:0] HAct = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] VAct = CNT_W'(V_ACTIVE);

  logic [DivW-1:0]  div_cnt_unused;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             tick, h_wrap, v_wrap;

  iob_vga_counter #(.N(CLK_DIV), .W(DivW)) u_div (
    .clk   (clk),
    .rst   (rst),
    .en_i  (1'b1),
    .cnt_o (div_cnt_unused),
    .wrap_o(tick)
  );

  iob_vga_counter #(.N(HTotal), .W(CNT_W)) u_h (
    .clk   (clk),
    .rst   (rst),
    .en_i  (tick),
    .cnt_o (h_cnt),
    .wrap_o(h_wrap)
  );

  iob_vga_counter #(.N(VTotal), .W(CNT_W)) u_v (
    .clk   (clk),
    .rst   (rst),
    .en_i  (h_wrap),
    .cnt_o (v_cnt),
    .wrap_o(v_wrap)
  );

  assign pixel_x     = h_cnt;
  assign pixel_y     = v_cnt;
  assign video_on    = (h_cnt < HAct) && (v_cnt < VAct);
  // v wraps only on the tick that also wraps h: the last pixel of a frame
  assign frame_start = v_wrap;

  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic [11:0] rgb_q, rgb_d;

  always_comb begin
    hs_d  = !((h_cnt >= HsBeg) && (h_cnt <= HsEnd));
    vs_d  = !((v_cnt >= VsBeg) && (v_cnt <= VsEnd));
    rgb_d = video_on ? vga_rgb_in : 12'h000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      rgb_q <= 12'h000;
    end else if (tick) begin
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      rgb_q <= rgb_d;
    end
  end

  assign vga_hs = hs_q;
  assign vga_vs = vs_q;
  assign vga_r  = rgb_q[RHi:RLo];
  assign vga_g  = rgb_q[GHi:GLo];
  assign vga_b  = rgb_q[BHi:BLo];

`ifdef VGA_FRAME_CNT_EN
  logic [31:0] fcnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt_q <= '0;
    end else if (frame_start) begin
      fcnt_q <= fcnt_q + 32'd1;
    end
  end

  assign frame_cnt = fcnt_q;
`endif

endmodule

// File: tb/tb_iob_vga_sync.sv
// Bench for iob_vga_sync on a reduced raster, checked every clock
// against a tick-count model of the timing rules.
module tb_iob_vga_sync;

  localparam int CD = 3;
  localparam int HA = 20;
  localparam int HF = 3;
  localparam int HS = 5;
  localparam int HB = 4;
  localparam int VA = 12;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int CW = 6;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int HS0 = HA + HF;
  localparam int HS1 = HA + HF + HS - 1;
  localparam int VS0 = VA + VF;
  localparam int VS1 = VA + VF + VS - 1;
  localparam int FRAME = CD * HT * VT;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [11:0]   rgb_in = 12'h000;
  logic [CW-1:0] pixel_x, pixel_y;
  logic          video_on, frame_start, vga_hs, vga_vs;
  logic [3:0]    vga_r, vga_g, vga_b;
`ifdef VGA_FRAME_CNT_EN
  logic [31:0]   frame_cnt;
`endif

  iob_vga_sync #(
    .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .CNT_W(CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .vga_rgb_in (rgb_in),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .video_on   (video_on),
    .frame_start(frame_start),
    .vga_hs     (vga_hs),
    .vga_vs     (vga_vs),
    .vga_r      (vga_r),
    .vga_g      (vga_g),
    .vga_b      (vga_b)
`ifdef VGA_FRAME_CNT_EN
    ,
    .frame_cnt  (frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int n;
  bit rgb_white;
  logic        e_hs, e_vs;
  logic [11:0] e_rgb;
  int          e_fc;

  function automatic int hpos(input int p);
    return p % HT;
  endfunction

  function automatic int vpos(input int p);
    return (p / HT) % VT;
  endfunction

  function automatic bit vis(input int p);
    return (hpos(p) < HA) && (vpos(p) < VA);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // n = clock edges since reset release; ticks so far = n / CD
  task automatic step();
    logic [11:0] drv;
    int t, p;
    bit tick_now, fs;
    drv = rgb_white ? 12'hFFF : 12'($urandom);
    rgb_in = drv;
    t = n / CD;
    tick_now = (n % CD) == CD - 1;
    fs = tick_now && ((t % (HT * VT)) == HT * VT - 1);
    chk("pixel_x", 32'(pixel_x), 32'(hpos(t)));
    chk("pixel_y", 32'(pixel_y), 32'(vpos(t)));
    chk("video_on", 32'(video_on), 32'(vis(t)));
    chk("frame_start", 32'(frame_start), 32'(fs));
    chk("vga_hs", 32'(vga_hs), 32'(e_hs));
    chk("vga_vs", 32'(vga_vs), 32'(e_vs));
    chk("rgb", 32'({vga_r, vga_g, vga_b}), 32'(e_rgb));
`ifdef VGA_FRAME_CNT_EN
    chk("frame_cnt", frame_cnt, 32'(e_fc));
`endif
    @(posedge clk);
    if (rst) begin
      n = 0;
      e_hs = 1'b1;
      e_vs = 1'b1;
      e_rgb = 12'h000;
      e_fc = 0;
    end else begin
      if (fs) e_fc++;
      n++;
      if (n % CD == 0) begin
        p = n / CD - 1;
        e_hs = !((hpos(p) >= HS0) && (hpos(p) <= HS1));
        e_vs = !((vpos(p) >= VS0) && (vpos(p) <= VS1));
        e_rgb = vis(p) ? drv : 12'h000;
      end
    end
    #1;
  endtask

  initial begin
    int vtarget;
    bit found;
    n = 0;
    e_hs = 1'b1;
    e_vs = 1'b1;
    e_rgb = 12'h000;
    e_fc = 0;
    rgb_white = 1'b1;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    step();
    rst = 1'b0;

    for (int i = 0; i < FRAME + 20; i++) step();
    rgb_white = 1'b0;
    for (int i = 0; i < FRAME + 40; i++) step();

    vtarget = $urandom_range(1, VT - 2);
    found = 1'b0;
    for (int i = 0; i < FRAME + CD; i++) begin
      if ((n % CD) == 1 && hpos(n / CD) == HS0 + 2 &&
          vpos(n / CD) == vtarget) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk("midframe_reached", 32'(found), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < FRAME + 60; i++) step();

    rgb_white = 1'b1;
    for (int i = 0; i < CD * HT * 2; i++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iob_vga_sync.md
Name: iob_vga_sync

Overview:
- VGA raster timing generator; sits directly upstream of the image-memory stage.
- Produces the pixel_x/pixel_y scan coordinates that the image memory consumes, and takes back its 12-bit rgb.
- Drives the board VGA pins: hsync, vsync, 4:4:4 RGB, blanked outside the active area.
- Default timing is 640x480@60 Hz from a 100 MHz clock, using a /4 pixel-tick enable.

Parameters:
- CLK_DIV, 4: system clocks per pixel; legal range 1..16.
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: hsync pulse width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: visible lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vsync pulse width, in lines.
- V_BP, 33: vertical back porch, in lines.
- CNT_W, 10: width of the h/v counters. H_TOTAL-1 and V_TOTAL-1 must fit in CNT_W bits.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset.
- vga_rgb_in, input, 12: colour from the image stage for the current pixel_x/pixel_y, {R[11:8],G[7:4],B[3:0]}.
- pixel_x, output, CNT_W: current horizontal count.
- pixel_y, output, CNT_W: current vertical count.
- video_on, output, 1: current count is inside the active area.
- frame_start, output, 1: one-clk pulse when the counters move to (0,0).
- vga_hs, output, 1: horizontal sync, active-low.
- vga_vs, output, 1: vertical sync, active-low.
- vga_r, output, 4: red to DAC.
- vga_g, output, 4: green to DAC.
- vga_b, output, 4: blue to DAC.
- frame_cnt, output, 32: frame counter; present only with VGA_FRAME_CNT_EN.

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high.
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
- Pixel tick:
  - div_cnt counts 0..CLK_DIV-1.
  - tick=1 when div_cnt==CLK_DIV-1. With CLK_DIV=1, tick is 1 every cycle.
- Horizontal counter:
  - h_cnt increments on tick.
  - When h_cnt==H_TOTAL-1 and tick, h_cnt goes to 0 and h_wrap=1.
- Vertical counter:
  - v_cnt increments on h_wrap.
  - When v_cnt==V_TOTAL-1 and h_wrap, v_cnt goes to 0.
- pixel_x=h_cnt and pixel_y=v_cnt, driven straight from the registers. The image stage is combinational, so vga_rgb_in is valid in the same cycles.
- video_on = (h_cnt<H_ACTIVE) && (v_cnt<V_ACTIVE), combinational.
- frame_start = tick && h_cnt==H_TOTAL-1 && v_cnt==V_TOTAL-1. It is high for exactly one clk per frame.
- Output stage, registered and updated only on tick:
  - vga_hs <= !(h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]); default range 656..751.
  - vga_vs <= !(v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]); default range 490..491.
  - {vga_r,vga_g,vga_b} <= video_on ? vga_rgb_in : 0.
  - Latency: sync and RGB lag pixel_x/pixel_y by exactly one pixel period (CLK_DIV clks). Sync and RGB are always mutually aligned.
- Reset values:
  - div_cnt=0, h_cnt=0, v_cnt=0, so pixel_x=0, pixel_y=0, video_on=1.
  - vga_hs=1, vga_vs=1, rgb=0, frame_start=0, frame_cnt=0.
- Reset mid-frame: all state returns to the reset values on the next clk edge, with no partial sync pulse. The first tick after reset moves h_cnt to 1.
- Simultaneous wraps: the h and v wraps occur on the same tick as frame_start. There is no extra cycle at the wrap.
- vga_rgb_in is ignored whenever video_on=0; blanking is forced to zero regardless of input.

Optional Feature:
- Macro: VGA_FRAME_CNT_EN.
- Defined: the frame_cnt port exists. It is a 32-bit register, reset 0, incremented on every frame_start, and wraps 0xFFFFFFFF to 0. Software can use it as a vsync/frame-rate reference.
- Undefined: no port and no register; everything else is identical.

Decomposition:
- Shared header iob_vga_defs.vh holds:
  - the default timing localparams;
  - H_TOTAL and V_TOTAL derivation;
  - the sync window start/end constants;
  - the RGB field slice constants (R 11:8, G 7:4, B 3:0).
- Sub-module iob_vga_counter: a mod-N counter with enable, synchronous reset and wrap flag output.
  - Instantiated three times: divider, horizontal, vertical.

Test Plan:
- Reset: hold rst 5 clks with CLK_DIV=4 -> pixel_x=0, pixel_y=0, vga_hs=1, vga_vs=1, rgb=0. After release, pixel_x becomes 1 at clk 4 and 2 at clk 8.
- Hsync: run one line -> vga_hs goes low at the tick one pixel after h_cnt=656 and stays low 96 ticks (384 clks). The line period is 3200 clks.
- Line and frame wrap: at h_cnt=799 with a tick -> h_cnt=0, v_cnt+1. At (799,524) -> frame_start for 1 clk and counters (0,0). Period is 1,680,000 clks. vga_vs is low for v=490..491 (6400 clks).
- Blanking: vga_rgb_in=12'hFFF constant -> RGB is F/F/F for h<640 and v<480, and 0 at h=640..799 and v>=480. The output changes one pixel after the counter crosses the boundary.
- Reset mid-frame: assert rst at h=700, v=300 during the sync pulse -> next clk gives vga_hs=1 and counters 0. The frame restarts and the following frame_start arrives 1,680,000 clks after reset release.
- CLK_DIV=1 and VGA_FRAME_CNT_EN: run 3 frames -> a tick every clk, frame_start every 420,000 clks, frame_cnt=3.
